// File: rtl/cnn_layer_accel_weight_loader.sv
// Streams 64-bit FIFO words into a 16-bit weight-table write port, one lane per cycle,
// for (num_kernels+1)*C_KERNEL_SLOTS writes, then pulses load_done.
module cnn_layer_accel_weight_loader #(
    parameter int C_CLG2_MAX_KERNELS = 6,
    parameter int C_KERNEL_SLOTS     = 16
) (
    input  logic                          clk_core,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
    input  logic [63:0]                   wht_fifo_dout,
    input  logic                          wht_fifo_empty,
    output logic                          wht_fifo_rden,
    output logic                          config_mode,
    output logic                          wht_config_wren,
    output logic [15:0]                   wht_config_data,
    output logic                          busy,
    output logic                          load_done
);

    localparam int CW = C_CLG2_MAX_KERNELS + 5;  // write counter width
    localparam int PW = C_CLG2_MAX_KERNELS + 3;  // word counter width
    localparam logic [CW-1:0] C_WR_ONE   = CW'(1);
    localparam logic [PW-1:0] C_WORD_ONE = PW'(1);
    localparam logic [CW-1:0] C_SLOTS    = CW'(C_KERNEL_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_total_writes;
    logic [PW-1:0]           r_total_words;
    logic [CW-1:0]           r_wr_cnt;
    logic [PW-1:0]           r_pop_cnt;
    logic [63:0]             r_buf;
    logic                    r_buf_valid;
    logic [1:0]              r_lane;
    logic                    r_config_mode;
    logic                    r_wren;
    logic [15:0]             r_data;
    logic                    r_load_done;

    logic [C_CLG2_MAX_KERNELS:0] w_kernels;
    logic [CW-1:0]           w_total_writes;
    logic [CW-1:0]           w_wr_cnt_nxt;
    logic                    w_issue;
    logic                    w_words_left;
    logic                    w_pop;
    logic                    w_last;
    logic [15:0]             w_lane_data;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_kernels      = {1'b0, num_kernels} + {{C_CLG2_MAX_KERNELS{1'b0}}, 1'b1};
        w_total_writes = CW'(w_kernels) * C_SLOTS;
        w_issue        = (r_state == S_LOAD) && r_buf_valid;
        w_words_left   = (r_pop_cnt != r_total_words);
        // Refill when the buffer is empty or its last lane drains this cycle; reset blocks a pop
        // so an aborted load never consumes a word it will throw away.
        w_pop          = !rst && (r_state == S_LOAD) && !wht_fifo_empty && w_words_left &&
                         (!r_buf_valid || (w_issue && (r_lane == 2'd3)));
        w_wr_cnt_nxt   = r_wr_cnt + C_WR_ONE;
        w_last         = w_issue && (w_wr_cnt_nxt == r_total_writes);
        w_lane_data    = r_buf[16*r_lane +: 16];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_total_writes <= '0;
            r_total_words  <= '0;
            r_wr_cnt       <= '0;
            r_pop_cnt      <= '0;
            r_buf_valid    <= 1'b0;
            r_lane         <= 2'd0;
            r_config_mode  <= 1'b0;
            r_wren         <= 1'b0;
            r_data         <= 16'd0;
            r_load_done    <= 1'b0;
        end else begin
            r_wren      <= w_issue;
            r_load_done <= 1'b0;
            if (w_issue) begin
                r_data <= w_lane_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state        <= S_LOAD;
                        r_config_mode  <= 1'b1;
                        r_total_writes <= w_total_writes;
                        r_total_words  <= w_total_writes[CW-1:2];
                        r_wr_cnt       <= '0;
                        r_pop_cnt      <= '0;
                        r_lane         <= 2'd0;
                        r_buf_valid    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_pop) begin
                        r_pop_cnt <= r_pop_cnt + C_WORD_ONE;
                    end
                    if (w_issue) begin
                        r_wr_cnt <= w_wr_cnt_nxt;
                        r_lane   <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_buf_valid <= w_pop;
                        end
                    end else if (w_pop) begin
                        r_buf_valid <= 1'b1;
                    end
                    if (w_last) begin
                        r_state       <= S_DONE;
                        r_config_mode <= 1'b0;
                        r_load_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the word buffer is datapath only and is not reset; r_buf_valid alone decides whether it is used.
    always_ff @(posedge clk_core) begin
        if (w_pop) begin
            r_buf <= wht_fifo_dout;
        end
    end

    assign wht_fifo_rden   = w_pop;
    assign config_mode     = r_config_mode;
    assign wht_config_wren = r_wren;
    assign wht_config_data = r_data;
    assign busy            = (r_state != S_IDLE);
    assign load_done       = r_load_done;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Directed bench: a FWFT FIFO model feeds the loader; a monitor checks each write against the
// FIFO contents in lane order and counts pops, writes, config_mode cycles and load_done pulses.
module tb_cnn_layer_accel_weight_loader;

    logic        clk_core = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [5:0]  num_kernels = 6'd0;
    logic [63:0] wht_fifo_dout;
    logic        wht_fifo_empty;
    logic        wht_fifo_rden;
    logic        config_mode;
    logic        wht_config_wren;
    logic [15:0] wht_config_data;
    logic        busy;
    logic        load_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall = 1'b0;
    logic        stall_en = 1'b0;

    int wr_seen = 0, pop_seen = 0, cfg_cycles = 0, done_cnt = 0, exp_idx = 0;
    int cycle = 0, first_wr = -1, last_wr = -1;

    cnn_layer_accel_weight_loader #(
        .C_CLG2_MAX_KERNELS(6),
        .C_KERNEL_SLOTS(16)
    ) dut (
        .clk_core(clk_core),
        .rst(rst),
        .load_start(load_start),
        .num_kernels(num_kernels),
        .wht_fifo_dout(wht_fifo_dout),
        .wht_fifo_empty(wht_fifo_empty),
        .wht_fifo_rden(wht_fifo_rden),
        .config_mode(config_mode),
        .wht_config_wren(wht_config_wren),
        .wht_config_data(wht_config_data),
        .busy(busy),
        .load_done(load_done)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [15:0] wval(input int idx);
        return 16'(idx) ^ 16'hC3A5;
    endfunction

    assign wht_fifo_dout  = mem[rd_ptr[9:0]];
    assign wht_fifo_empty = stall || (rd_ptr == wr_ptr);

    always @(posedge clk_core) begin
        if (wht_fifo_rden) rd_ptr <= rd_ptr + 1;
        stall <= stall_en && ($urandom_range(0, 1) == 1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_core) begin
        cycle++;
        if (wht_config_wren) begin
            check("wr_data", 64'(wht_config_data), 64'(wval(exp_idx)));
            exp_idx++;
            wr_seen++;
            if (first_wr < 0) first_wr = cycle;
            last_wr = cycle;
        end
        if (wht_fifo_rden) begin
            check("pop_when_empty", 64'(wht_fifo_empty), 64'd0);
            pop_seen++;
        end
        if (config_mode) cfg_cycles++;
        if (load_done) done_cnt++;
    end

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = {wval(4*wr_ptr+3), wval(4*wr_ptr+2), wval(4*wr_ptr+1), wval(4*wr_ptr)};
            wr_ptr++;
        end
    endtask

    task automatic clr();
        wr_seen = 0; pop_seen = 0; cfg_cycles = 0; done_cnt = 0;
        first_wr = -1; last_wr = -1;
        exp_idx = rd_ptr * 4;
    endtask

    task automatic start(input logic [5:0] nk);
        num_kernels = nk;
        load_start  = 1'b1;
        @(negedge clk_core);
        load_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk_core);
            n++;
        end
        check(tag, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk_core);
    endtask

    initial begin
        // Reset held together with load_start: reset must win.
        load_start = 1'b1;
        repeat (3) @(negedge clk_core);
        load_start = 1'b0;
        rst = 1'b0;
        @(negedge clk_core);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg", 64'(config_mode), 64'd0);
        check("rst_wren", 64'(wht_config_wren), 64'd0);
        check("rst_data", 64'(wht_config_data), 64'd0);
        check("rst_rden", 64'(wht_fifo_rden), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);

        // One kernel, data always available.
        push(4);
        clr();
        start(6'd0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done", 200);
        check("t1_writes", 64'(wr_seen), 64'd16);
        check("t1_pops", 64'(pop_seen), 64'd4);
        check("t1_back_to_back", 64'(last_wr - first_wr), 64'd15);
        check("t1_cfg_cycles", 64'(cfg_cycles), 64'd17);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        check("t1_idle", 64'(busy), 64'd0);

        // Three kernels, 13 words queued, FIFO empty flag toggling randomly.
        push(13);
        clr();
        stall_en = 1'b1;
        start(6'd2);
        wait_done("t2_done", 2000);
        stall_en = 1'b0;
        check("t2_writes", 64'(wr_seen), 64'd48);
        check("t2_pops", 64'(pop_seen), 64'd12);
        check("t2_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
        check("t2_cfg_off", 64'(config_mode), 64'd0);

        // load_start pulsed mid-load is ignored.
        push(3);
        clr();
        start(6'd0);
        repeat (5) @(negedge clk_core);
        start(6'd3);
        wait_done("t3_done", 200);
        repeat (5) @(negedge clk_core);
        check("t3_writes", 64'(wr_seen), 64'd16);
        check("t3_pops", 64'(pop_seen), 64'd4);
        check("t3_done_pulses", 64'(done_cnt), 64'd1);
        check("t3_idle", 64'(busy), 64'd0);

        // Reset right after write index 7 is seen, then a fresh load.
        push(4);
        clr();
        start(6'd0);
        begin
            int k = 0;
            int n = 0;
            while (k < 8 && n < 100) begin
                @(negedge clk_core);
                n++;
                if (wht_config_wren) k++;
            end
            check("t4_reach_write7", 64'(k), 64'd8);
        end
        rst = 1'b1;
        @(negedge clk_core);
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_cfg", 64'(config_mode), 64'd0);
        check("t4_rst_wren", 64'(wht_config_wren), 64'd0);
        check("t4_rst_data", 64'(wht_config_data), 64'd0);
        check("t4_rst_rden", 64'(wht_fifo_rden), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk_core);
        check("t4_abort_writes", 64'(wr_seen), 64'd8);
        check("t4_abort_pops", 64'(pop_seen), 64'd3);
        push(3);
        clr();
        start(6'd0);
        wait_done("t4_restart_done", 200);
        check("t4_restart_writes", 64'(wr_seen), 64'd16);
        check("t4_restart_pops", 64'(pop_seen), 64'd4);

        // Maximum kernel count: 1024 writes from 256 words.
        push(256);
        clr();
        start(6'd63);
        wait_done("t5_done", 3000);
        check("t5_writes", 64'(wr_seen), 64'd1024);
        check("t5_pops", 64'(pop_seen), 64'd256);
        check("t5_fifo_left", 64'(wr_ptr - rd_ptr), 64'd0);
        check("t5_done_pulses", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
